fifo_rd_stream: RTL and testbench

Read-side drain engine for the team's single-clock FIFO. It pops words through the FIFO's read port (rd_en/data_out/empty) and presents them downstream as a valid/ready stream. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so it sustains one word per cycle under continuous ready. It sits between the FIFO's read port and any stream consumer, which sees no dependency on FIFO timing.

---
 rtl/fifo_rd_pkg.sv | 9 +
 rtl/fifo_rd_skid.sv | 53 +++++
 rtl/fifo_rd_stream.sv | 57 +++++
 tb/tb_fifo_rd_stream.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-side stream engine.
package fifo_rd_pkg;

    localparam int BUF_DEPTH = 2;

    // Buffer occupancy, 0..BUF_DEPTH.
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry circular output buffer that absorbs the FIFO's registered read latency.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output occ_t             count
);

    logic [width-1:0] buf_mem [BUF_DEPTH];
    logic             head;
    logic             tail;
    occ_t             count_nxt;

    always_comb begin
        count_nxt = count;
        case ({wr, rd})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= '0;
        end else begin
            // The issue rule guarantees a write never lands on the entry being read.
            if (wr) begin
                buf_mem[tail] <= wdata;
                tail          <= ~tail;
            end
            if (rd) begin
                head <= ~head;
            end
            count <= count_nxt;
        end
    end

    assign rdata = buf_mem[head];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the FIFO read port into a valid/ready stream at one word per cycle.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             fifo_rd_en,
    input  logic [width-1:0] fifo_data_out,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [width-1:0] m_data
);

    occ_t             count;
    occ_t             occupied;
    logic             inflight;
    logic             pop;
    logic [width-1:0] head_data;

    assign pop      = m_valid & m_ready;
    assign occupied = count + {1'b0, inflight};

    // A slot is free if buffer plus in-flight words leave room, or one drains this cycle.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (!rst && !fifo_empty) begin
            fifo_rd_en = (occupied < 2'd2) || ((occupied == 2'd2) && pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_rd_skid #(
        .width (width)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .wr    (inflight),
        .wdata (fifo_data_out),
        .rd    (pop),
        .rdata (head_data),
        .count (count)
    );

    assign m_valid = (count != 2'd0);
    assign m_data  = head_data;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream driven by a behavioural single-clock FIFO.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_rd_en;
    logic [7:0] fifo_data_out = '0;
    logic       fifo_empty;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:63];
    int         wp = 0;
    int         rp = 0;
    int         n_out  = 0;
    int         n_disc = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_rd_stream #(.width(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data)
    );

    // FIFO model: registered read data, empty flag updates at the edge after a pop.
    assign fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data_out <= mem[rp];
            rp            <= rp + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] w);
        mem[wp] = w;
        wp      = wp + 1;
        exp_q.push_back(w);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stream rules.
    initial begin : monitor
        logic       hold;
        logic [7:0] held_data;
        logic [7:0] e;
        hold = 1'b0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(m_valid), 32'd1);
                    check("hold_data", 32'(m_data), 32'(held_data));
                end
                check("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
                check("outstanding_le_2", 32'((rp - n_out - n_disc) <= 2), 32'd1);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", 32'(m_data), 32'(e));
                    end
                    n_out++;
                end
                hold      = m_valid && !m_ready;
                held_data = m_data;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "timeout");
    end

    localparam logic [7:0] ALT_WORDS [16] = '{
        8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h7E, 8'h81,
        8'h9A, 8'h5B, 8'hE4, 8'h06, 8'h70, 8'hD1, 8'h2F, 8'hB8
    };

    initial begin : stim
        int         base;
        int         n;
        logic [7:0] w;

        // Reset then idle with an empty FIFO.
        tick();
        tick();
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_m_valid", 32'(m_valid), 32'd0);
            check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
            check("idle_m_data", 32'(m_data), 32'd0);
        end

        // Streaming 0x01..0x08 with continuous ready.
        base    = rp;
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) load(8'(i));
        #1;
        check("stream_first_rd_en", 32'(fifo_rd_en), 32'd1);
        tick();
        check("stream_valid_c1", 32'(m_valid), 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(i + 1));
            tick();
        end
        check("stream_pops", 32'(rp - base), 32'd8);
        check("stream_valid_after", 32'(m_valid), 32'd0);

        // Back-pressure: only two words may leave the FIFO.
        base    = rp;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(8'hA0 + 8'(i));
        for (int i = 0; i < 6; i++) tick();
        check("bp_pops", 32'(rp - base), 32'd2);
        check("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'hA0);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("bp_release_valid", 32'(m_valid), 32'd1);
            check("bp_release_data", 32'(m_data), 32'hA0 + 32'(i));
            tick();
        end
        wait_drain(20);

        // Alternating ready with a 16-word directed pattern.
        for (int i = 0; i < 16; i++) load(ALT_WORDS[i]);
        for (int i = 0; i < 60; i++) begin
            m_ready = ~i[0];
            tick();
        end
        m_ready = 1'b1;
        wait_drain(40);
        check("alt_all_out", 32'(exp_q.size()), 32'd0);

        // Single word.
        m_ready = 1'b0;
        base    = rp;
        load(8'h5A);
        for (int i = 0; i < 5; i++) tick();
        check("single_pops", 32'(rp - base), 32'd1);
        check("single_valid", 32'(m_valid), 32'd1);
        check("single_data", 32'(m_data), 32'h5A);
        m_ready = 1'b1;
        tick();
        check("single_valid_after", 32'(m_valid), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("single_no_second_rd", 32'(rp - base), 32'd1);
        check("single_still_idle", 32'(m_valid), 32'd0);

        // Reset mid-stream with one word buffered and one in flight.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(8'hB0 + 8'(i));
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("midrst_data", 32'(m_data), 32'd0);
        check("midrst_popped", 32'(rp - (wp - 6)), 32'd2);
        n_disc = rp - n_out;
        exp_q.delete();
        for (int i = rp; i < wp; i++) exp_q.push_back(mem[i]);
        tick();
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (!m_valid && n < 10) begin
            tick();
            n++;
        end
        check("midrst_wait_valid", 32'(m_valid), 32'd1);
        w = m_data;
        check("midrst_first_word", 32'(w), 32'hB2);
        wait_drain(20);

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
